// File: rtl/audio_mixer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_mixer_pkg
//  Description : Shared audio definitions: mixer FSM states and sample width.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_mixer_pkg;

    // Sample width shared by the mixer output and the PWM data port
    localparam int unsigned c_audio_width = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } mix_state_t;

endpackage
`default_nettype wire

// File: rtl/audio_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : audio_mixer
//  Description : Sequential N-channel gain mixer with one shared multiplier,
//                shifted and saturated to the PWM sample width.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_mixer
    import audio_mixer_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned IN_WIDTH   = 4,
    parameter int unsigned GAIN_WIDTH = 4,
    parameter int unsigned WIDTH      = c_audio_width,
    parameter int unsigned SHIFT      = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             sample_tick,
    input  logic [NUM_CH*IN_WIDTH-1:0]       ch_data,
    input  logic [NUM_CH*GAIN_WIDTH-1:0]     ch_gain,
    input  logic [NUM_CH-1:0]                ch_enable,
    output logic [WIDTH-1:0]                 data,
    output logic                             valid,
    output logic                             busy,
    output logic                             overrun
);

    localparam int unsigned c_idx_w   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned c_prod_w  = IN_WIDTH + GAIN_WIDTH;
    localparam int unsigned c_acc_w   = c_prod_w + $clog2(NUM_CH);
    localparam int unsigned c_shift_w = c_acc_w + SHIFT;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_CH - 1);

    mix_state_t                      r_state;
    logic [NUM_CH*IN_WIDTH-1:0]      r_amp_snap;
    logic [NUM_CH*GAIN_WIDTH-1:0]    r_gain_snap;
    logic [NUM_CH-1:0]               r_en_snap;
    logic [c_acc_w-1:0]              r_acc;
    logic [c_idx_w-1:0]              r_idx;
    logic [WIDTH-1:0]                r_data;
    logic                            r_valid;
    logic                            r_busy;
    logic                            r_overrun;

    logic [IN_WIDTH-1:0]             w_amp;
    logic [GAIN_WIDTH-1:0]           w_gain;
    logic                            w_en;
    logic [c_prod_w-1:0]             w_prod;
    logic [c_prod_w-1:0]             w_term;
    logic [c_shift_w-1:0]            w_shifted;
    logic [WIDTH-1:0]                w_sat;

    // Channel index steers the snapshot into the single shared multiplier
    always_comb begin
        w_amp  = '0;
        w_gain = '0;
        w_en   = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_amp  = r_amp_snap[i*IN_WIDTH +: IN_WIDTH];
                w_gain = r_gain_snap[i*GAIN_WIDTH +: GAIN_WIDTH];
                w_en   = r_en_snap[i];
            end
        end
    end

    assign w_prod    = c_prod_w'(w_amp) * c_prod_w'(w_gain);
    assign w_term    = w_en ? w_prod : '0;
    assign w_shifted = c_shift_w'(r_acc) << SHIFT;

    generate
        if (c_shift_w > WIDTH) begin : g_sat
            assign w_sat = (|w_shifted[c_shift_w-1:WIDTH]) ? '1 : w_shifted[WIDTH-1:0];
        end else begin : g_nosat
            assign w_sat = WIDTH'(w_shifted);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_amp_snap  <= '0;
            r_gain_snap <= '0;
            r_en_snap   <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sample_tick) begin
                        r_amp_snap  <= ch_data;
                        r_gain_snap <= ch_gain;
                        r_en_snap   <= ch_enable;
                        r_acc       <= '0;
                        r_idx       <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (sample_tick) r_overrun <= 1'b1;
                    r_acc <= r_acc + c_acc_w'(w_term);
                    if (r_idx == c_last_idx) begin
                        r_state <= OUTPUT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (sample_tick) r_overrun <= 1'b1;
                    r_data  <= w_sat;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign data    = r_data;
    assign valid   = r_valid;
    assign busy    = r_busy;
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_audio_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_mixer
//  Description : Scoreboard bench for audio_mixer (default and SHIFT=3 builds).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_mixer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic        sample_tick_s = 1'b0;
    logic [15:0] ch_data = '0;
    logic [15:0] ch_gain = '0;
    logic [3:0]  ch_enable = '0;

    logic [11:0] data, data_s;
    logic        valid, busy, overrun;
    logic        valid_s, busy_s, overrun_s;

    audio_mixer #(.NUM_CH(4), .IN_WIDTH(4), .GAIN_WIDTH(4), .WIDTH(12), .SHIFT(2)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick),
        .ch_data(ch_data), .ch_gain(ch_gain), .ch_enable(ch_enable),
        .data(data), .valid(valid), .busy(busy), .overrun(overrun)
    );

    audio_mixer #(.NUM_CH(4), .IN_WIDTH(4), .GAIN_WIDTH(4), .WIDTH(12), .SHIFT(3)) dut_sat (
        .clk(clk), .reset(reset), .sample_tick(sample_tick_s),
        .ch_data(ch_data), .ch_gain(ch_gain), .ch_enable(ch_enable),
        .data(data_s), .valid(valid_s), .busy(busy_s), .overrun(overrun_s)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          valid_cnt = 0;
    logic [11:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mix_model(input logic [15:0] d, input logic [15:0] g,
                                     input logic [3:0] e, input int shift);
        int s = 0;
        for (int i = 0; i < 4; i++)
            if (e[i]) s += int'(d[i*4 +: 4]) * int'(g[i*4 +: 4]);
        s = s << shift;
        if (s > 4095) s = 4095;
        return s;
    endfunction

    always @(posedge clk) begin
        #1;
        if (valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) check("unexpected_valid", 32'(valid), 0);
            else                   check("sb_data", 32'(data), 32'(exp_q.pop_front()));
        end
    end

    task automatic run_pass(input logic [15:0] d, input logic [15:0] g, input logic [3:0] e,
                            output int lat, output int busy_n);
        @(negedge clk);
        ch_data = d; ch_gain = g; ch_enable = e; sample_tick = 1'b1;
        exp_q.push_back(12'(mix_model(d, g, e, 2)));
        @(posedge clk); #1;
        sample_tick = 1'b0;
        busy_n = busy ? 1 : 0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (busy) busy_n++;
            if (valid) begin lat = k; break; end
        end
    endtask

    task automatic run_sat(input logic [15:0] d, input logic [15:0] g, input logic [3:0] e,
                           input string tag);
        int seen = 0;
        @(negedge clk);
        ch_data = d; ch_gain = g; ch_enable = e; sample_tick_s = 1'b1;
        @(negedge clk);
        sample_tick_s = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (valid_s) begin seen = 1; break; end
        end
        check({tag, "_valid"}, 32'(seen), 1);
        check(tag, 32'(data_s), 32'(mix_model(d, g, e, 3)));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bn, v0;
        logic [15:0] d_a, g_a, d_b, g_b;

        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(data), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        @(negedge clk) reset = 1'b0;

        // Full scale on all channels
        run_pass(16'hFFFF, 16'hFFFF, 4'hF, lat, bn);
        check("max_latency", 32'(lat), 5);
        check("max_busy_cycles", 32'(bn), 5);

        // Channel 2 alone, taken immediately after the previous valid
        run_pass(16'h0700, 16'h0300, 4'b0100, lat, bn);
        check("ch2_latency", 32'(lat), 5);
        check("ch2_busy_cycles", 32'(bn), 5);

        for (int r = 0; r < 4; r++) begin
            run_pass(16'($urandom), 16'($urandom), 4'($urandom), lat, bn);
            check("rand_latency", 32'(lat), 5);
        end
        check("b2b_no_overrun", 32'(overrun), 0);

        // Inputs change the cycle after the tick
        d_a = 16'h1234; g_a = 16'h5678; d_b = 16'hFFFF; g_b = 16'hFFFF;
        @(negedge clk);
        ch_data = d_a; ch_gain = g_a; ch_enable = 4'hF; sample_tick = 1'b1;
        exp_q.push_back(12'(mix_model(d_a, g_a, 4'hF, 2)));
        @(negedge clk);
        sample_tick = 1'b0; ch_data = d_b; ch_gain = g_b; ch_enable = 4'b0001;
        repeat (10) @(negedge clk);

        // Second tick two cycles into a pass
        v0 = valid_cnt;
        @(negedge clk);
        ch_data = 16'h9ABC; ch_gain = 16'h2345; ch_enable = 4'b1011; sample_tick = 1'b1;
        exp_q.push_back(12'(mix_model(16'h9ABC, 16'h2345, 4'b1011, 2)));
        @(negedge clk) sample_tick = 1'b0;
        @(negedge clk);
        ch_data = 16'hFFFF; ch_gain = 16'h1111; ch_enable = 4'hF; sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
        repeat (10) @(negedge clk);
        check("ovr_valid_pulses", 32'(valid_cnt - v0), 1);
        check("ovr_flag", 32'(overrun), 1);

        // Reset two cycles into a pass
        @(negedge clk);
        ch_data = 16'hFFFF; ch_gain = 16'hFFFF; ch_enable = 4'hF; sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        v0 = valid_cnt;
        repeat (8) @(negedge clk);
        check("abort_valid_pulses", 32'(valid_cnt - v0), 0);
        check("abort_data", 32'(data), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_overrun", 32'(overrun), 0);

        run_pass(16'h4321, 16'h8765, 4'b1101, lat, bn);
        check("post_abort_latency", 32'(lat), 5);

        run_sat(16'hFFFF, 16'hFFFF, 4'hF, "sat_max");
        run_sat(16'h000F, 16'h000F, 4'b0001, "sat_ch0");

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
